// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32-style datapath: fetch, decode, execute,
// memory and write-back sequencing, with a sticky illegal-opcode trap and a retire counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [1:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ir_we,
    output logic        pc_we,
    output logic        branch,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic        retire,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_I      = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5
    } class_t;

    state_t state_q, state_d;
    class_t class_q, dec_class;
    logic   illegal_q;

    assign state   = state_q;
    assign illegal = illegal_q;

    always_comb begin
        case (opcode)
            7'b0110011: dec_class = C_R;
            7'b0010011: dec_class = C_I;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
            default:    dec_class = C_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            class_q   <= C_NONE;
            illegal_q <= 1'b0;
            instret   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                class_q <= dec_class;
                if (dec_class == C_NONE) illegal_q <= 1'b1;
            end
            if (retire) instret <= instret + 32'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        alu_op     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        branch     = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req  = 1'b1;
                alu_src_b = 2'b01;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                state_d   = (dec_class == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (class_q)
                    C_R:      begin alu_op = 2'b10;                      state_d = S_WB;  end
                    C_I:      begin alu_op = 2'b10; alu_src_b = 2'b10;   state_d = S_WB;  end
                    C_LOAD,
                    C_STORE:  begin alu_src_b = 2'b10;                   state_d = S_MEM; end
                    C_BRANCH: begin
                        alu_op  = 2'b01;
                        branch  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default:  state_d = S_TRAP;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == C_STORE);
                if (dmem_ack) begin
                    if (class_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (class_q == C_LOAD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset must silence every output combinationally, not just after the next edge.
        if (!rst_n) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            alu_op     = 2'b00;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            branch     = 1'b0;
            reg_we     = 1'b0;
            mem_to_reg = 1'b0;
            retire     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction drivers with a memory responder,
// and a retire monitor that pops expected retire-cycle outputs and counter values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we;
    logic [1:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ir_we, pc_we, branch, reg_we, mem_to_reg;
    logic        illegal, retire;
    logic [31:0] instret;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_cnt = 32'd0;

    logic [12:0] exp_q[$];
    logic [31:0] exp_cnt_q[$];

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ir_we(ir_we), .pc_we(pc_we),
        .branch(branch), .reg_we(reg_we), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .retire(retire), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] rec(input logic [2:0] st, input logic rw, input logic m2r,
                                        input logic dreq, input logic dwe, input logic br,
                                        input logic [1:0] aop, input logic asa, input logic [1:0] asb);
        return {st, rw, m2r, dreq, dwe, br, aop, asa, asb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
        end
    endtask

    // Runs one instruction from FETCH to its retire cycle, acting as instruction/data memory.
    task automatic run_instr(input string name, input logic [6:0] op, input int iw, input int dw,
                             input logic noisy, input logic [12:0] exp_rec, input int exp_cyc,
                             input logic [29:0] exp_trace, input int exp_br, input int exp_rw);
        int cyc = 0, ic = 0, dc = 0, br_cnt = 0, rw_cnt = 0;
        logic [29:0] trace = '0;
        logic done = 1'b0;
        model_cnt = model_cnt + 32'd1;
        exp_q.push_back(exp_rec);
        exp_cnt_q.push_back(model_cnt);
        opcode = op;
        while (!done && cyc < 40) begin
            @(negedge clk);
            imem_ack = (state == 3'd0) ? (ic >= iw) : noisy;
            dmem_ack = (state == 3'd3) ? (dc >= dw) : noisy;
            if (state == 3'd0) ic++;
            if (state == 3'd3) dc++;
            #1;
            trace = {trace[26:0], state};
            cyc++;
            if (branch) br_cnt++;
            if (reg_we) rw_cnt++;
            if (retire) done = 1'b1;
        end
        check({name, " retired"}, {31'd0, done}, 32'd1);
        check({name, " cycles"}, cyc, exp_cyc);
        check({name, " state trace"}, {2'b0, trace}, {2'b0, exp_trace});
        check({name, " branch cycles"}, br_cnt, exp_br);
        check({name, " reg_we cycles"}, rw_cnt, exp_rw);
    endtask

    // Retire monitor: pops expected outputs on each retire pulse, then checks the counter one cycle later.
    initial begin
        logic        cnt_pending = 1'b0;
        logic [31:0] cnt_exp = '0;
        forever begin
            @(negedge clk);
            #2;
            if (cnt_pending) begin
                check("instret after retire", instret, cnt_exp);
                cnt_pending = 1'b0;
            end
            if (retire) begin
                if (exp_q.size() == 0) begin
                    check("unexpected retire", 32'd1, 32'd0);
                end else begin
                    check("retire outputs",
                          {19'd0, state, reg_we, mem_to_reg, dmem_req, dmem_we, branch, alu_op, alu_src_a, alu_src_b},
                          {19'd0, exp_q.pop_front()});
                    cnt_exp = exp_cnt_q.pop_front();
                    cnt_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        // Reset behaviour
        repeat (2) @(negedge clk);
        #1;
        check("reset state", {29'd0, state}, 32'd0);
        check("reset imem_req", {31'd0, imem_req}, 32'd0);
        check("reset instret", instret, 32'd0);
        check("reset illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("imem_req after reset", {31'd0, imem_req}, 32'd1);
        check("fetch alu_src_b", {30'd0, alu_src_b}, 32'd1);
        check("fetch pc_we while waiting", {31'd0, pc_we}, 32'd0);

        // Legal instruction classes
        run_instr("R", OP_R, 0, 0, 1'b0, rec(3'd4, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00), 4, 30'o0124, 0, 1);
        idle(1);
        run_instr("LOAD wait2", OP_LD, 0, 2, 1'b0, rec(3'd4, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00), 7, 30'o0123334, 0, 1);
        idle(1);
        run_instr("BRANCH", OP_BR, 0, 0, 1'b0, rec(3'd2, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00), 3, 30'o012, 1, 0);
        idle(1);
        run_instr("STORE", OP_ST, 0, 0, 1'b0, rec(3'd3, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00), 4, 30'o0123, 0, 0);
        idle(1);
        run_instr("I iwait1", OP_I, 1, 0, 1'b0, rec(3'd4, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00), 5, 30'o00124, 0, 1);
        idle(1);
        run_instr("LOAD noisy", OP_LD, 0, 1, 1'b1, rec(3'd4, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00), 6, 30'o012334, 0, 1);
        idle(2);
        check("instret after six", instret, 32'd6);

        // Reset while waiting in MEM
        opcode = OP_ST;
        @(negedge clk); imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("MEM wait state", {29'd0, state}, 32'd3);
        check("MEM wait dmem_req", {31'd0, dmem_req}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async reset dmem_req", {31'd0, dmem_req}, 32'd0);
        check("async reset dmem_we", {31'd0, dmem_we}, 32'd0);
        check("async reset state", {29'd0, state}, 32'd0);
        check("async reset instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 32'd0;

        // Illegal opcode trap
        opcode = OP_BAD;
        @(negedge clk); imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            #1;
            if (i == 0 || i == 11) begin
                check("trap state", {29'd0, state}, 32'd5);
                check("trap illegal", {31'd0, illegal}, 32'd1);
                check("trap imem_req", {31'd0, imem_req}, 32'd0);
                check("trap strobes",
                      {21'd0, dmem_req, ir_we, pc_we, reg_we, retire, alu_op, alu_src_a, alu_src_b},
                      32'd0);
            end
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        check("illegal cleared", {31'd0, illegal}, 32'd0);
        check("fetch after trap", {30'd0, state, imem_req}, 32'd1);

        // Counter wrap
        @(negedge clk);
        force dut.instret = 32'hFFFF_FFFF;
        #1 release dut.instret;
        model_cnt = 32'hFFFF_FFFF;
        run_instr("STORE wrap", OP_ST, 0, 0, 1'b0, rec(3'd3, 0, 0, 1, 1, 0, 2'b00, 0, 2'b00), 4, 30'o0123, 0, 0);
        idle(3);
        check("instret wrapped", instret, 32'd0);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 opcode  in  7  instruction-register opcode field, valid from DECODE onward.
REQ-005 imem_ack  in  1  instruction fetch complete; instruction data presented same cycle.
REQ-006 dmem_ack  in  1  data access complete; load data presented same cycle.
REQ-007 imem_req  out  1  fetch request.
REQ-008 dmem_req / dmem_we  out  1 / 1  data access request and store qualifier.
REQ-009 alu_op  out  2  ALU control class: 00 add, 01 subtract-compare, 10 decode from funct3/funct7.
REQ-010 alu_src_a  out  1  0 = PC, 1 = rs1.
REQ-011 alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate, 11 unused.
REQ-012 ir_we / pc_we / branch / reg_we / mem_to_reg  out  1 each  register-file and PC strobes.
REQ-013 illegal  out  1  sticky illegal-opcode flag.
REQ-014 retire  out  1  one-cycle pulse per completed instruction.
REQ-015 instret  out  32  retired-instruction counter.
REQ-016 state  out  3  current state encoding, for debug.

Function
REQ-017 FSM states SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH on the next edge.
REQ-018 FETCH: imem_req=1, alu_src_a=0, alu_src_b=01, alu_op=00; while imem_ack=0 the FSM stays in FETCH with ir_we=pc_we=0.
REQ-019 FETCH with imem_ack=1: ir_we=1 and pc_we=1 in that same cycle (PC <- PC+4); next state DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute); opcode SHALL be classified and latched into an internal class register.
REQ-021 Legal classes: R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011; any other opcode SHALL go DECODE->TRAP.
REQ-022 EXEC, R: alu_src_a=1, alu_src_b=00, alu_op=10; next WB.
REQ-023 EXEC, I: alu_src_a=1, alu_src_b=10, alu_op=10; next WB.
REQ-024 EXEC, LOAD/STORE: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM.
REQ-025 EXEC, BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, branch=1 for exactly one cycle, retire=1; next FETCH.
REQ-026 MEM: dmem_req=1, dmem_we=1 only for STORE; the FSM holds until dmem_ack=1; then LOAD goes to WB, STORE goes to FETCH with retire=1.
REQ-027 WB: reg_we=1, mem_to_reg=1 only for LOAD, retire=1; next FETCH.
REQ-028 TRAP: illegal=1 and all strobes/requests=0; TRAP SHALL be left only by reset.
REQ-029 Any strobe not explicitly asserted for a state SHALL be 0; alu_* outputs SHALL be 0 in WB, MEM and TRAP.
REQ-030 On every retire pulse, instret SHALL increment by 1, wrapping 0xFFFFFFFF -> 0.
REQ-031 Latency with zero-wait memory SHALL be: R/I 4 cycles, BRANCH 3, STORE 4, LOAD 5, each extended by one cycle per wait cycle.
REQ-032 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.

Reset
REQ-033 While rst_n=0, state SHALL be FETCH, class register cleared, instret=0, illegal=0, and all strobes 0.
REQ-034 Reset assertion mid-instruction (including while waiting in MEM or TRAP) SHALL abort immediately with no partial strobe after the asynchronous assertion.
REQ-035 After rst_n deasserts, imem_req SHALL be 1 in the first cycle.

Verification
REQ-036 R-type 0110011, imem_ack=1 immediately -> states 0,1,2,4; reg_we=1 in cycle 4; instret 0->1.
REQ-037 LOAD 0000011, dmem_ack delayed 2 cycles -> MEM held 3 cycles; mem_to_reg=1 and reg_we=1 in WB; total 7 cycles.
REQ-038 BRANCH 1100011 -> branch=1 for one cycle in EXEC, alu_op=01; returns to FETCH, reg_we never asserted.
REQ-039 Opcode 1111111 -> TRAP, illegal=1, imem_req=0 for 10 or more cycles; rst_n pulse clears illegal and resumes FETCH.
REQ-040 Preload instret=0xFFFFFFFF via 2^32 retires or forced state, then one STORE retires -> instret=0.
REQ-041 rst_n asserted in MEM waiting on dmem_ack -> dmem_req drops asynchronously; state=0; instret=0.
